sample_trigger: RTL and testbench

Trigger and capture controller placed directly upstream of the sampler, in the sampled-signal clock domain.
- Registers the probe bus into a one-cycle pipeline and drives it onto the sampler's write-side data input.
- Drives the sampler's write-side active-low reset, so the sampler only starts filling once a masked pattern or edge condition has fired and an optional post-trigger delay has elapsed.
- Watches the sampler's done flag and reports status back to software-facing logic.

---
 rtl/sample_trigger.sv | 156 +++++++++++++++
 tb/tb_sample_trigger.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sample_trigger.sv
// Trigger/capture controller in front of the sampler: registers the probe bus and releases
// the sampler reset after a pattern/edge trigger plus delay. SAMPLE_TRIGGER_ARM_SYNC_EN adds an arm synchronizer.
module sample_trigger #(
    parameter int width     = 32,
    parameter int delayBits = 16,
    parameter int waitBits  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arm,
    input  logic [width-1:0]     trig_mask,
    input  logic [width-1:0]     trig_value,
    input  logic                 trig_edge,
    input  logic [delayBits-1:0] delay,
    input  logic [width-1:0]     data_in,
    output logic [width-1:0]     data_out,
    output logic                 sampler_reset_n,
    input  logic                 sampler_done,
    output logic                 triggered,
    output logic                 busy,
    output logic                 done,
    output logic [waitBits-1:0]  wait_cycles
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        DELAY   = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [width-1:0]     data_out_q;
    logic                 match_prev_q;
    logic [delayBits-1:0] cnt_q, cnt_d;
    logic [waitBits-1:0]  wait_q, wait_d;
    logic                 sampler_reset_n_q, sampler_reset_n_d;
    logic                 triggered_q, triggered_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 arm_use;
    logic                 match;
    logic                 trig;

`ifdef SAMPLE_TRIGGER_ARM_SYNC_EN
    logic arm_meta_q, arm_sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arm_meta_q <= 1'b0;
            arm_sync_q <= 1'b0;
        end else begin
            arm_meta_q <= arm;
            arm_sync_q <= arm_meta_q;
        end
    end

    assign arm_use = arm_sync_q;
`else
    assign arm_use = arm;
`endif

    assign match = (((data_in ^ trig_value) & trig_mask) == '0);
    assign trig  = trig_edge ? (match & ~match_prev_q) : match;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wait_d      = wait_q;
        triggered_d = 1'b0;
        // Disarm wins over everything, including a trigger in the same cycle.
        case (state_q)
            IDLE: begin
                if (arm_use) begin
                    state_d = ARMED;
                    wait_d  = '0;
                end
            end
            ARMED: begin
                if (!arm_use) begin
                    state_d = IDLE;
                end else if (trig) begin
                    triggered_d = 1'b1;
                    if (delay == '0) begin
                        state_d = CAPTURE;
                    end else begin
                        state_d = DELAY;
                        cnt_d   = delay - delayBits'(1);
                    end
                end else if (wait_q != '1) begin
                    wait_d = wait_q + waitBits'(1);
                end
            end
            DELAY: begin
                if (!arm_use) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q - delayBits'(1);
                end
            end
            CAPTURE: begin
                if (!arm_use) begin
                    state_d = IDLE;
                end else if (sampler_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!arm_use) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status outputs are registered decodes of the state being entered.
        sampler_reset_n_d = (state_d == CAPTURE) || (state_d == DONE);
        busy_d            = (state_d == ARMED) || (state_d == DELAY) || (state_d == CAPTURE);
        done_d            = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= IDLE;
            data_out_q        <= '0;
            match_prev_q      <= 1'b0;
            cnt_q             <= '0;
            wait_q            <= '0;
            sampler_reset_n_q <= 1'b0;
            triggered_q       <= 1'b0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
        end else begin
            state_q           <= state_d;
            data_out_q        <= data_in;
            match_prev_q      <= match;
            cnt_q             <= cnt_d;
            wait_q            <= wait_d;
            sampler_reset_n_q <= sampler_reset_n_d;
            triggered_q       <= triggered_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
        end
    end

    assign data_out        = data_out_q;
    assign sampler_reset_n = sampler_reset_n_q;
    assign triggered       = triggered_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign wait_cycles     = wait_q;

endmodule

// File: tb/tb_sample_trigger.sv
// Randomized and directed bench for sample_trigger against a cycle-level behavioural model.
module tb_sample_trigger;

    localparam int W  = 32;
    localparam int DB = 8;
    localparam int WB = 8;
    localparam int WAIT_MAX = (1 << WB) - 1;
`ifdef SAMPLE_TRIGGER_ARM_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          arm;
    logic [W-1:0]  trig_mask, trig_value;
    logic          trig_edge;
    logic [DB-1:0] delay;
    logic [W-1:0]  data_in;
    logic [W-1:0]  data_out;
    logic          sampler_reset_n;
    logic          sampler_done;
    logic          triggered, busy, done;
    logic [WB-1:0] wait_cycles;

    sample_trigger #(.width(W), .delayBits(DB), .waitBits(WB)) dut (
        .clk(clk), .reset(reset), .arm(arm), .trig_mask(trig_mask), .trig_value(trig_value),
        .trig_edge(trig_edge), .delay(delay), .data_in(data_in), .data_out(data_out),
        .sampler_reset_n(sampler_reset_n), .sampler_done(sampler_done), .triggered(triggered),
        .busy(busy), .done(done), .wait_cycles(wait_cycles)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 armed, 2 delay, 3 capture, 4 done.
    int           m_phase, m_wait, m_rem, cap_cycles, done_lat;
    bit           m_trig, m_mprev, a1, a2;
    logic [W-1:0] m_data, last_first;
    logic [W-1:0] hist[$];
    int           cyc, trig_cyc, trig_dly;
    int           rise_k, srn_cnt, trig_cnt;

    task automatic model_reset();
        m_phase = 0; m_wait = 0; m_rem = 0; cap_cycles = 0;
        m_trig = 0; m_mprev = 0; a1 = 0; a2 = 0; m_data = '0;
    endtask

    task automatic cycle();
        bit arm_e, match, t, enter_cap;
        int nxt;
        arm_e = (SYNC_LAT != 0) ? a2 : arm;
        match = (((data_in ^ trig_value) & trig_mask) == '0);
        t     = trig_edge ? (match && !m_mprev) : match;
        m_trig = 0;
        nxt = m_phase;
        if (m_phase == 0) begin
            if (arm_e) begin nxt = 1; m_wait = 0; end
        end else if (!arm_e) begin
            nxt = 0;
        end else if (m_phase == 1) begin
            if (t) begin
                m_trig = 1; trig_cyc = cyc; trig_dly = int'(delay);
                if (delay == 0) nxt = 3;
                else begin m_rem = int'(delay); nxt = 2; end
            end else if (m_wait < WAIT_MAX) m_wait++;
        end else if (m_phase == 2) begin
            m_rem--;
            if (m_rem == 0) nxt = 3;
        end else if (m_phase == 3) begin
            if (sampler_done) nxt = 4;
        end
        hist.push_back(data_in);
        m_data = data_in; m_mprev = match; a2 = a1; a1 = arm;
        enter_cap = (nxt == 3) && (m_phase != 3);
        m_phase = nxt;
        cap_cycles = (m_phase >= 3) ? cap_cycles + 1 : 0;
        @(posedge clk); #1;
        cyc++;
        check("data_out", data_out, m_data);
        check("triggered", triggered, m_trig);
        check("sampler_reset_n", sampler_reset_n, m_phase >= 3);
        check("busy", busy, (m_phase >= 1) && (m_phase <= 3));
        check("done", done, m_phase == 4);
        check("wait_cycles", wait_cycles, 64'(m_wait));
        if (enter_cap) begin
            check("first_word", data_out, hist[trig_cyc + trig_dly]);
            last_first = data_out;
        end
        if (triggered) trig_cnt++;
        if (sampler_reset_n) srn_cnt++;
        if (m_trig)
            $display("trigger cyc=%0d data=0x%0h delay=%0d wait=%0d", cyc, m_data, trig_dly, m_wait);
        sampler_done = (m_phase >= 3) && (cap_cycles >= done_lat);
    endtask

    // Armed run; counting data steps by one, otherwise random low nibble data.
    task automatic run(input int budget, input bit counting, input bit rnd_delay,
                       input int abort_k, input int abort_dly, input bit tail);
        int dly_seen = 0;
        int done_seen = 0;
        rise_k = -1; srn_cnt = 0; trig_cnt = 0;
        arm = 1'b1;
        for (int k = 0; k < budget; k++) begin
            cycle();
            if (sampler_reset_n && rise_k < 0) rise_k = k;
            data_in = counting ? data_in + 1 : ($urandom & 32'hFFFF_FF0F) | 32'($urandom_range(0, 15));
            if (rnd_delay) delay = DB'($urandom_range(0, 12));
            if (m_phase == 2) dly_seen++;
            if (abort_k >= 0 && k + 1 >= abort_k) arm = 1'b0;
            if (abort_dly >= 0 && dly_seen == abort_dly) arm = 1'b0;
            if (m_phase == 4) done_seen++;
            if (done_seen == 3) break;
            if (!arm && m_phase == 0 && k > abort_k + SYNC_LAT + 2) break;
        end
        if (tail) begin
            arm = 1'b0;
            for (int k = 0; k < SYNC_LAT + 2; k++) cycle();
        end
    endtask

    int rise1;

    initial begin
        reset = 1'b1; arm = 1'b0; trig_mask = '0; trig_value = '0; trig_edge = 1'b0;
        delay = '0; data_in = '0; sampler_done = 1'b0; cyc = 0; done_lat = 1;
        model_reset();
        #12;
        check("rst_data_out", data_out, 0);
        check("rst_srn", sampler_reset_n, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wait", wait_cycles, 0);
        reset = 1'b0;

        // Level trigger on 0x5A, no delay, long sampler fill then disarm.
        trig_mask = 32'hFF; trig_value = 32'h5A; data_in = '0; done_lat = 1024;
        run(1300, 1, 0, -1, -1, 1);
        check("s1_first_word", last_first, 32'h5A);
        check("s1_wait", wait_cycles, 64'(32'h59 - SYNC_LAT));
        check("s1_rise", rise_k, 32'h5A);
        rise1 = rise_k;

        // Same with delay 3.
        delay = 3; data_in = '0; done_lat = 8;
        run(400, 1, 0, -1, -1, 1);
        check("s2_first_word", last_first, 32'h5D);
        check("s2_rise_shift", rise_k - rise1, 3);

        // Edge mode: bit0 held high while arming, then 0, then 1.
        delay = 0; trig_mask = 32'h1; trig_value = 32'h1; trig_edge = 1'b1; data_in = 32'h1;
        for (int k = 0; k < 3; k++) cycle();
        arm = 1'b1; trig_cnt = 0;
        for (int k = 0; k < 6 + SYNC_LAT; k++) cycle();
        check("s3_no_trig_held", trig_cnt, 0);
        data_in = 32'h0; cycle();
        data_in = 32'h1; cycle();
        check("s3_edge_trig", triggered, 1);
        arm = 1'b0;
        for (int k = 0; k < SYNC_LAT + 2; k++) cycle();

        // Abort in the second DELAY cycle.
        trig_edge = 1'b0; trig_mask = 32'hFF; trig_value = 32'h10; delay = 10; data_in = '0;
        run(200, 1, 0, -1, 2, 1);
        check("s5_srn_never", srn_cnt, 0);
        check("s5_busy", busy, 0);

        // Wait counter saturation with a pattern that never matches.
        trig_value = 32'hFFFF_FFFF; trig_mask = 32'hFFFF_FFFF; data_in = '0; delay = 0;
        arm = 1'b1;
        for (int k = 0; k < 300; k++) begin cycle(); data_in = data_in + 1; end
        check("sat_wait", wait_cycles, WAIT_MAX);
        arm = 1'b0;
        for (int k = 0; k < SYNC_LAT + 2; k++) cycle();

        // Randomized scenarios with live delay changes and random aborts.
        for (int s = 0; s < 40; s++) begin
            trig_mask  = 32'($urandom_range(0, 15));
            trig_value = $urandom;
            trig_edge  = 1'($urandom_range(0, 1));
            done_lat   = $urandom_range(1, 30);
            run(300, 0, 1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 40)) : -1, -1, 1);
        end

        // Asynchronous reset in the middle of a capture.
        trig_mask = 32'hFF; trig_value = 32'h5; trig_edge = 1'b0; delay = 0;
        data_in = '0; done_lat = 1000;
        run(20, 1, 0, -1, -1, 0);
        check("s6_in_capture", sampler_reset_n, 1);
        reset = 1'b1; #1;
        check("s6_rst_data_out", data_out, 0);
        check("s6_rst_srn", sampler_reset_n, 0);
        check("s6_rst_trig", triggered, 0);
        check("s6_rst_busy", busy, 0);
        check("s6_rst_done", done, 0);
        check("s6_rst_wait", wait_cycles, 0);
        @(negedge clk);
        reset = 1'b0; arm = 1'b0; sampler_done = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
